seven_seg_decoder: RTL and testbench

- Receive-side counterpart of the multiplexed seven-segment display driver.
- Samples the scanned active-low segment/anode bus and rebuilds the 16-bit hex value being displayed.
- Used as on-board readback and self-check of the display path, and as a bench monitor.
- Flags segment patterns that are not a legal hex glyph.

---
 rtl/seven_seg_decoder.sv | 175 +++++++++++++++++
 tb/tb_seven_seg_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_decoder.sv
// Readback decoder for a scanned, active-low 4-digit seven-segment bus; rebuilds the 16-bit hex value.
// Optional stale-frame watchdog enabled by defining SEVSEG_DEC_TIMEOUT_EN.
module seven_seg_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  anodes,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic        code_err,
  output logic [1:0]  err_digit,
  output logic        stale
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       seg_q, seg_p;
  logic [3:0]       an_q, an_p;
  logic [15:0]      slots;
  logic [3:0]       mask;
  logic             cap_err_q;
  logic [1:0]       cap_idx_q;

  logic             an_ok;
  logic [1:0]       an_idx;
  logic             same;
  logic             g_ok;
  logic [3:0]       g_nib;

  function automatic logic [4:0] glyph_decode(input logic [6:0] s);
    case (s)
      7'b0000001: glyph_decode = {1'b1, 4'h0};
      7'b1001111: glyph_decode = {1'b1, 4'h1};
      7'b0010010: glyph_decode = {1'b1, 4'h2};
      7'b0000110: glyph_decode = {1'b1, 4'h3};
      7'b1001100: glyph_decode = {1'b1, 4'h4};
      7'b0100100: glyph_decode = {1'b1, 4'h5};
      7'b0100000: glyph_decode = {1'b1, 4'h6};
      7'b0001111: glyph_decode = {1'b1, 4'h7};
      7'b0000000: glyph_decode = {1'b1, 4'h8};
      7'b0001100: glyph_decode = {1'b1, 4'h9};
      7'b0001000: glyph_decode = {1'b1, 4'hA};
      7'b1100000: glyph_decode = {1'b1, 4'hB};
      7'b0110001: glyph_decode = {1'b1, 4'hC};
      7'b1000010: glyph_decode = {1'b1, 4'hD};
      7'b0110000: glyph_decode = {1'b1, 4'hE};
      7'b0111000: glyph_decode = {1'b1, 4'hF};
      default:    glyph_decode = {1'b0, 4'h0};
    endcase
  endfunction

  always_comb begin
    an_ok  = 1'b1;
    an_idx = 2'd0;
    case (an_q)
      4'b1110: an_idx = 2'd0;
      4'b1101: an_idx = 2'd1;
      4'b1011: an_idx = 2'd2;
      4'b0111: an_idx = 2'd3;
      default: an_ok  = 1'b0;
    endcase
  end

  assign same           = ({seg_q, an_q} == {seg_p, an_p});
  assign {g_ok, g_nib}  = glyph_decode(seg_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q       <= '1;
      seg_p       <= '1;
      an_q        <= '1;
      an_p        <= '1;
      state       <= IDLE;
      cnt         <= '0;
      slots       <= '0;
      mask        <= '0;
      value       <= '0;
      frame_valid <= 1'b0;
      code_err    <= 1'b0;
      err_digit   <= 2'd0;
      cap_err_q   <= 1'b0;
      cap_idx_q   <= 2'd0;
    end else begin
      seg_q       <= seg;
      an_q        <= anodes;
      seg_p       <= seg_q;
      an_p        <= an_q;
      frame_valid <= 1'b0;
      code_err    <= 1'b0;
      cap_err_q   <= 1'b0;

      // Illegal-glyph report is delayed one cycle so it lines up with frame completion timing.
      if (cap_err_q) begin
        code_err  <= 1'b1;
        err_digit <= cap_idx_q;
      end

      case (state)
        IDLE: begin
          if (an_ok) begin
            state <= SETTLE;
            cnt   <= CNT_W'(1);
          end
        end
        SETTLE: begin
          if (!an_ok) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (!same) begin
            cnt <= CNT_W'(1);
          end else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            state <= HOLD;
            cnt   <= CNT_W'(SETTLE_CYCLES);
            if (g_ok) begin
              slots[{an_idx, 2'b00} +: 4] <= g_nib;
              mask[an_idx]                <= 1'b1;
            end else begin
              cap_err_q <= 1'b1;
              cap_idx_q <= an_idx;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (!same) begin
            if (an_ok) begin
              state <= SETTLE;
              cnt   <= CNT_W'(1);
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      // Placed last so completion overrides any mask update in the same cycle.
      if (mask == 4'hF) begin
        value       <= slots;
        frame_valid <= 1'b1;
        mask        <= '0;
      end
    end
  end

`ifdef SEVSEG_DEC_TIMEOUT_EN
  logic [31:0] tcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (frame_valid) begin
      tcnt <= '0;
    end else if (tcnt < 32'(TIMEOUT_CYCLES)) begin
      tcnt <= tcnt + 32'd1;
    end
  end

  assign stale = (tcnt >= 32'(TIMEOUT_CYCLES));
`else
  assign stale = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Directed self-checking bench for seven_seg_decoder (default build, watchdog disabled).
module tb_seven_seg_decoder;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  anodes;
  logic [15:0] value;
  logic        frame_valid;
  logic        code_err;
  logic [1:0]  err_digit;
  logic        stale;

  int checks;
  int errors;
  int cyc;
  int fv_cnt;
  int fv_cyc;
  int err_cnt;
  int both_cnt;
  int c3;
  int fv0;
  int er0;
  logic [6:0] glyph [16];

  seven_seg_decoder #(
    .SETTLE_CYCLES (16),
    .CNT_W         (8),
    .TIMEOUT_CYCLES(1000000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg        (seg),
    .anodes     (anodes),
    .value      (value),
    .frame_valid(frame_valid),
    .code_err   (code_err),
    .err_digit  (err_digit),
    .stale      (stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    fv_cnt   = 0;
    fv_cyc   = 0;
    err_cnt  = 0;
    both_cnt = 0;
  end

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt = fv_cnt + 1;
      fv_cyc = cyc;
    end
    if (code_err) err_cnt = err_cnt + 1;
    if (frame_valid && code_err) both_cnt = both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] s, input int n);
    anodes = an;
    seg    = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan_digits(input logic [15:0] v, input int first, input int last, input int n);
    logic [3:0] an;
    for (int d = first; d <= last; d++) begin
      an    = 4'hF;
      an[d] = 1'b0;
      if (d == 3) c3 = cyc;
      hold(an, glyph[v[4*d +: 4]], n);
    end
  endtask

  task automatic snap();
    fv0 = fv_cnt;
    er0 = err_cnt;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    glyph[0]  = 7'b0000001; glyph[1]  = 7'b1001111; glyph[2]  = 7'b0010010; glyph[3]  = 7'b0000110;
    glyph[4]  = 7'b1001100; glyph[5]  = 7'b0100100; glyph[6]  = 7'b0100000; glyph[7]  = 7'b0001111;
    glyph[8]  = 7'b0000000; glyph[9]  = 7'b0001100; glyph[10] = 7'b0001000; glyph[11] = 7'b1100000;
    glyph[12] = 7'b0110001; glyph[13] = 7'b1000010; glyph[14] = 7'b0110000; glyph[15] = 7'b0111000;

    rst_n  = 1'b0;
    seg    = 7'h7F;
    anodes = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_value", 32'(value), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_code_err", 32'(code_err), 32'h0);
    check("rst_err_digit", 32'(err_digit), 32'h0);
    check("rst_stale", 32'(stale), 32'h0);
    rst_n = 1'b1;
    hold(4'hF, 7'h7F, 3);

    // 10 cycles per digit is too short to settle
    snap();
    scan_digits(16'h1A3F, 0, 3, 10);
    hold(4'hF, 7'h7F, 20);
    check("short_dwell_fv", 32'(fv_cnt - fv0), 32'd0);
    check("short_dwell_value", 32'(value), 32'h0);

    snap();
    scan_digits(16'h1A3F, 0, 3, 20);
    hold(4'hF, 7'h7F, 5);
    check("scan_1A3F_value", 32'(value), 32'h1A3F);
    check("scan_1A3F_fv_count", 32'(fv_cnt - fv0), 32'd1);
    check("scan_1A3F_latency", 32'(fv_cyc - c3), 32'd18);
    check("scan_1A3F_code_err", 32'(err_cnt - er0), 32'd0);

    snap();
    hold(4'b1011, 7'h7F, 20);
    hold(4'hF, 7'h7F, 5);
    check("blank_code_err", 32'(err_cnt - er0), 32'd1);
    check("blank_err_digit", 32'(err_digit), 32'd2);
    check("blank_fv", 32'(fv_cnt - fv0), 32'd0);

    snap();
    scan_digits(16'h0042, 0, 3, 20);
    hold(4'hF, 7'h7F, 5);
    check("scan_0042_value", 32'(value), 32'h0042);
    check("scan_0042_fv_count", 32'(fv_cnt - fv0), 32'd1);

    snap();
    scan_digits(16'hBEEF, 0, 2, 20);
    hold(4'b1100, glyph[8], 50);
    check("multi_low_fv", 32'(fv_cnt - fv0), 32'd0);
    check("multi_low_value", 32'(value), 32'h0042);
    scan_digits(16'hBEEF, 3, 3, 20);
    hold(4'hF, 7'h7F, 5);
    check("scan_BEEF_value", 32'(value), 32'hBEEF);
    check("scan_BEEF_fv_count", 32'(fv_cnt - fv0), 32'd1);

    snap();
    hold(4'b1110, glyph[1], 1000);
    scan_digits(16'h0000, 1, 3, 20);
    hold(4'hF, 7'h7F, 5);
    check("long_dwell_value", 32'(value), 32'h0001);
    check("long_dwell_fv_count", 32'(fv_cnt - fv0), 32'd1);
    check("long_dwell_code_err", 32'(err_cnt - er0), 32'd0);

    scan_digits(16'h9999, 0, 2, 20);
    hold(4'b0111, glyph[9], 8);
    rst_n  = 1'b0;
    anodes = 4'hF;
    seg    = 7'h7F;
    @(negedge clk);
    check("midreset_value", 32'(value), 32'h0);
    check("midreset_fv", 32'(frame_valid), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold(4'hF, 7'h7F, 4);

    snap();
    scan_digits(16'h5678, 3, 3, 20);
    hold(4'hF, 7'h7F, 5);
    check("after_reset_partial_fv", 32'(fv_cnt - fv0), 32'd0);
    check("after_reset_partial_value", 32'(value), 32'h0);
    scan_digits(16'h5678, 0, 3, 20);
    hold(4'hF, 7'h7F, 5);
    check("scan_5678_value", 32'(value), 32'h5678);
    check("scan_5678_fv_count", 32'(fv_cnt - fv0), 32'd1);

    check("fv_code_err_overlap", 32'(both_cnt), 32'd0);
    check("stale_disabled", 32'(stale), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
